// File: rtl/kyber_pkg.sv
// Shared constants, stream type codes and sequencer states for the Kyber CPA encrypt block (K=3).
package kyber_pkg;

    localparam int K          = 3;
    localparam int DU         = 10;
    localparam int DV         = 4;
    localparam int EK_BYTES   = 384 * K;
    localparam int CT_WORDS   = (32 * (K * DU + DV)) / 2;
    localparam int CT_PAIRS   = CT_WORDS / 2;
    localparam int SEED_BYTES = 32;                    // r, m and rho are all 32 bytes

    localparam int T_AW    = $clog2(EK_BYTES);
    localparam int CT_AW   = $clog2(CT_WORDS);
    localparam int SEED_AW = $clog2(SEED_BYTES);

    localparam logic [3:0] TYPE_NONE = 4'd0;
    localparam logic [3:0] TYPE_R    = 4'd1;
    localparam logic [3:0] TYPE_T    = 4'd2;
    localparam logic [3:0] TYPE_M    = 4'd3;
    localparam logic [3:0] TYPE_RHO  = 4'd4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_R,
        ST_LOAD_T,
        ST_LOAD_M,
        ST_LOAD_RHO,
        ST_GAP,
        ST_COMPUTE,
        ST_STREAM,
        ST_DONE
    } state_t;

    // Stream code the host must present while a load state is active.
    function automatic logic [3:0] type_of(state_t s);
        case (s)
            ST_LOAD_R:   return TYPE_R;
            ST_LOAD_T:   return TYPE_T;
            ST_LOAD_M:   return TYPE_M;
            ST_LOAD_RHO: return TYPE_RHO;
            default:     return TYPE_NONE;
        endcase
    endfunction

    // Where the sequencer goes once the gap that follows a load has elapsed.
    function automatic state_t next_stage(state_t s);
        case (s)
            ST_LOAD_R:   return ST_LOAD_T;
            ST_LOAD_T:   return ST_LOAD_M;
            ST_LOAD_M:   return ST_LOAD_RHO;
            default:     return ST_COMPUTE;
        endcase
    endfunction

endpackage

// File: rtl/kyber_enc_core.sv
// Stand-in polynomial core: writes out_mem[n] = n ^ 16'hA5A5 one word per cycle,
// then raises done for one cycle a fixed number of cycles after the last write.
module kyber_enc_core
    import kyber_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               done,
    output logic [SEED_AW-1:0] r_addr,
    input  logic [7:0]         r_data,
    output logic [T_AW-1:0]    t_addr,
    input  logic [7:0]         t_data,
    output logic [SEED_AW-1:0] m_addr,
    input  logic [7:0]         m_data,
    output logic [SEED_AW-1:0] rho_addr,
    input  logic [7:0]         rho_data,
    output logic               ct_we,
    output logic [CT_AW-1:0]   ct_waddr,
    output logic [15:0]        ct_wdata
);

    localparam int TAIL_CYCLES = 10;

    typedef enum logic [1:0] {C_IDLE, C_WRITE, C_TAIL} cstate_t;

    cstate_t          cst;
    logic [CT_AW-1:0] cnt;

    // Buffer read ports are swept but the stub does not depend on their contents.
    assign r_addr   = cnt[SEED_AW-1:0];
    assign t_addr   = T_AW'(cnt);
    assign m_addr   = cnt[SEED_AW-1:0];
    assign rho_addr = cnt[SEED_AW-1:0];

    logic unused_rd;
    assign unused_rd = ^{r_data, t_data, m_data, rho_data};

    // Write sweep then fixed tail; a new start always restarts from word 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cst      <= C_IDLE;
            cnt      <= '0;
            done     <= 1'b0;
            ct_we    <= 1'b0;
            ct_waddr <= '0;
            ct_wdata <= '0;
        end else begin
            done  <= 1'b0;
            ct_we <= 1'b0;
            if (start) begin
                cst <= C_WRITE;
                cnt <= '0;
            end else begin
                case (cst)
                    C_WRITE: begin
                        ct_we    <= 1'b1;
                        ct_waddr <= cnt;
                        ct_wdata <= 16'(cnt) ^ 16'hA5A5;
                        if (cnt == CT_AW'(CT_WORDS - 1)) begin
                            cst <= C_TAIL;
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    C_TAIL: begin
                        if (cnt == CT_AW'(TAIL_CYCLES - 1)) begin
                            done <= 1'b1;
                            cst  <= C_IDLE;
                            cnt  <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: cst <= C_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/kyber_pke_enc.sv
// CPA encryption sequencer: loads r, t, m, rho byte streams, kicks the core,
// then streams the ciphertext out two 16-bit words per cycle.
module kyber_pke_enc
    import kyber_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        set,
    input  logic        readin,
    input  logic        readout,
    input  logic        full_in,
    input  logic [3:0]  data_type,
    input  logic [7:0]  kyber_din,
    input  logic [15:0] kyber_in_index,
    output logic [3:0]  input_type,
    output logic        readin_ok,
    output logic [15:0] kyber_dout_1,
    output logic [15:0] kyber_dout_2,
    output logic [15:0] kyber_out_index,
    output logic        done
);

    state_t state, gap_next;
    logic   gap_cnt;
    logic   core_start, core_done;

    logic [7:0]  buf_r   [SEED_BYTES];
    logic [7:0]  buf_t   [EK_BYTES];
    logic [7:0]  buf_m   [SEED_BYTES];
    logic [7:0]  buf_rho [SEED_BYTES];
    logic [15:0] out_mem [CT_WORDS];

    logic [SEED_AW-1:0] r_addr, m_addr, rho_addr;
    logic [T_AW-1:0]    t_addr;
    logic [7:0]         r_data, t_data, m_data, rho_data;
    logic               ct_we;
    logic [CT_AW-1:0]   ct_waddr;
    logic [15:0]        ct_wdata;

    // readin_ok is high exactly in the load states and input_type carries that
    // state's code, so together they qualify a host byte.
    logic wr_ok;
    assign wr_ok = readin && readin_ok && (data_type == input_type);

    // Pair index that the stream advances to next.
    logic [CT_AW-2:0] nxt_pair;
    assign nxt_pair = kyber_out_index[CT_AW-2:0] + 1'b1;

    // Combinational read ports for the core.
    assign r_data   = buf_r[r_addr];
    assign t_data   = buf_t[t_addr];
    assign m_data   = buf_m[m_addr];
    assign rho_data = buf_rho[rho_addr];

    // Host byte writes; out-of-range indices are silently dropped.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            if (input_type == TYPE_R && kyber_in_index < 16'(SEED_BYTES))
                buf_r[kyber_in_index[SEED_AW-1:0]] <= kyber_din;
            if (input_type == TYPE_T && kyber_in_index < 16'(EK_BYTES))
                buf_t[kyber_in_index[T_AW-1:0]] <= kyber_din;
            if (input_type == TYPE_M && kyber_in_index < 16'(SEED_BYTES))
                buf_m[kyber_in_index[SEED_AW-1:0]] <= kyber_din;
            if (input_type == TYPE_RHO && kyber_in_index < 16'(SEED_BYTES))
                buf_rho[kyber_in_index[SEED_AW-1:0]] <= kyber_din;
        end
    end

    // Ciphertext words from the core.
    always_ff @(posedge clk) begin
        if (ct_we && ct_waddr < CT_AW'(CT_WORDS))
            out_mem[ct_waddr] <= ct_wdata;
    end

    // Sequencer with registered host-facing outputs; set=0 acts as a soft reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= ST_IDLE;
            gap_next        <= ST_IDLE;
            gap_cnt         <= 1'b0;
            core_start      <= 1'b0;
            input_type      <= TYPE_NONE;
            readin_ok       <= 1'b0;
            kyber_dout_1    <= '0;
            kyber_dout_2    <= '0;
            kyber_out_index <= '0;
            done            <= 1'b0;
        end else if (!set) begin
            state           <= ST_IDLE;
            gap_next        <= ST_IDLE;
            gap_cnt         <= 1'b0;
            core_start      <= 1'b0;
            input_type      <= TYPE_NONE;
            readin_ok       <= 1'b0;
            kyber_dout_1    <= '0;
            kyber_dout_2    <= '0;
            kyber_out_index <= '0;
            done            <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state      <= ST_LOAD_R;
                    input_type <= TYPE_R;
                    readin_ok  <= 1'b1;
                end
                ST_LOAD_R, ST_LOAD_T, ST_LOAD_M, ST_LOAD_RHO: begin
                    if (full_in) begin
                        state      <= ST_GAP;
                        gap_next   <= next_stage(state);
                        gap_cnt    <= 1'b0;
                        input_type <= TYPE_NONE;
                        readin_ok  <= 1'b0;
                    end
                end
                // Two idle cycles so the host can reset its byte counter.
                ST_GAP: begin
                    if (!gap_cnt) begin
                        gap_cnt <= 1'b1;
                    end else begin
                        state <= gap_next;
                        if (gap_next == ST_COMPUTE) begin
                            core_start <= 1'b1;
                        end else begin
                            input_type <= type_of(gap_next);
                            readin_ok  <= 1'b1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (core_done) begin
                        state           <= ST_STREAM;
                        kyber_out_index <= '0;
                        kyber_dout_1    <= out_mem[0];
                        kyber_dout_2    <= out_mem[1];
                    end
                end
                ST_STREAM: begin
                    if (!readout) begin
                        if (kyber_out_index == 16'(CT_PAIRS - 1)) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            kyber_out_index <= kyber_out_index + 16'd1;
                            kyber_dout_1    <= out_mem[{nxt_pair, 1'b0}];
                            kyber_dout_2    <= out_mem[{nxt_pair, 1'b1}];
                        end
                    end
                end
                ST_DONE: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

    kyber_enc_core u_core (
        .clk      (clk),
        .reset    (reset),
        .start    (core_start),
        .done     (core_done),
        .r_addr   (r_addr),
        .r_data   (r_data),
        .t_addr   (t_addr),
        .t_data   (t_data),
        .m_addr   (m_addr),
        .m_data   (m_data),
        .rho_addr (rho_addr),
        .rho_data (rho_data),
        .ct_we    (ct_we),
        .ct_waddr (ct_waddr),
        .ct_wdata (ct_wdata)
    );

endmodule

// File: tb/tb_kyber_pke_enc.sv
// Bench for kyber_pke_enc with the stub core: load rules, gap timing, stream order, stalls, resets.
module tb_kyber_pke_enc;
    import kyber_pkg::*;

    logic        clk = 1'b0;
    logic        reset, set, readin, readout, full_in;
    logic [3:0]  data_type;
    logic [7:0]  kyber_din;
    logic [15:0] kyber_in_index;
    logic [3:0]  input_type;
    logic        readin_ok, done;
    logic [15:0] kyber_dout_1, kyber_dout_2, kyber_out_index;

    kyber_pke_enc dut (
        .clk(clk), .reset(reset), .set(set), .readin(readin), .readout(readout),
        .full_in(full_in), .data_type(data_type), .kyber_din(kyber_din),
        .kyber_in_index(kyber_in_index), .input_type(input_type), .readin_ok(readin_ok),
        .kyber_dout_1(kyber_dout_1), .kyber_dout_2(kyber_dout_2),
        .kyber_out_index(kyber_out_index), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference buffer contents, indexed by stream code.
    logic [7:0] ref_buf [5][EK_BYTES];

    typedef struct {
        logic [3:0]  dt;
        logic [15:0] idx;
        logic [7:0]  din;
        logic        rd;
        int          chk_idx;
        logic [7:0]  exp;
    } vec_t;
    vec_t vt [8];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int len_of(logic [3:0] t);
        return (t == TYPE_T) ? EK_BYTES : SEED_BYTES;
    endfunction

    function automatic logic [7:0] dut_buf(logic [3:0] t, int i);
        case (t)
            TYPE_R:   return dut.buf_r[i[SEED_AW-1:0]];
            TYPE_T:   return dut.buf_t[i[T_AW-1:0]];
            TYPE_M:   return dut.buf_m[i[SEED_AW-1:0]];
            default:  return dut.buf_rho[i[SEED_AW-1:0]];
        endcase
    endfunction

    task automatic check_zero(string name);
        chk({name, "_type"}, 32'(input_type), 0);
        chk({name, "_ok"},   32'(readin_ok), 0);
        chk({name, "_d1"},   32'(kyber_dout_1), 0);
        chk({name, "_d2"},   32'(kyber_dout_2), 0);
        chk({name, "_idx"},  32'(kyber_out_index), 0);
        chk({name, "_done"}, 32'(done), 0);
    endtask

    // One host byte cycle; the model applies the write rule to what the host sent.
    task automatic send(logic [3:0] dt, logic [15:0] idx, logic [7:0] d, logic rd,
                        logic fl, logic [3:0] cur);
        data_type = dt; kyber_in_index = idx; kyber_din = d; readin = rd; full_in = fl;
        step();
        if (rd && dt == cur && int'(idx) < len_of(cur)) ref_buf[cur][idx] = d;
        readin = 1'b0; full_in = 1'b0;
    endtask

    // Full load of one stream with random junk interleaved, then gap timing checks.
    task automatic load_phase(logic [3:0] cur, bit seq_data, bit garbage_tail);
        int len = len_of(cur);
        logic [3:0] nxt = (cur == TYPE_RHO) ? TYPE_NONE : cur + 4'd1;
        chk("load_type", 32'(input_type), 32'(cur));
        chk("load_ok", 32'(readin_ok), 1);
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: send(4'((int'(cur) + 1 + $urandom_range(0, 3)) % 5), 16'(i), 8'($urandom), 1'b1, 1'b0, cur);
                    1: send(cur, 16'($urandom_range(0, len - 1)), 8'($urandom), 1'b0, 1'b0, cur);
                    2: send(cur, 16'(len + $urandom_range(0, 1000)), 8'($urandom), 1'b1, 1'b0, cur);
                    default: send(cur, 16'($urandom_range(0, len - 1)), 8'($urandom), 1'b1, 1'b0, cur);
                endcase
            end
            send(cur, 16'(i), seq_data ? 8'(i) : 8'($urandom), 1'b1,
                 (!garbage_tail && i == len - 1), cur);
        end
        if (garbage_tail) send(cur, 16'(len), 8'($urandom), 1'b1, 1'b1, cur);
        for (int i = 0; i < len; i++)
            chk($sformatf("buf%0d_%0d", cur, i), 32'(dut_buf(cur, i)), 32'(ref_buf[cur][i]));
        chk("gap1_type", 32'(input_type), 0);
        chk("gap1_ok", 32'(readin_ok), 0);
        step();
        chk("gap2_type", 32'(input_type), 0);
        chk("gap2_ok", 32'(readin_ok), 0);
        step();
        chk("next_type", 32'(input_type), 32'(nxt));
        chk("next_ok", 32'(readin_ok), (nxt != TYPE_NONE) ? 32'd1 : 32'd0);
    endtask

    task automatic wait_stream();
        bit found = 0;
        for (int c = 0; c < 3000 && !found; c++) begin
            if (kyber_dout_1 == 16'hA5A5) found = 1;
            else step();
        end
        chk("stream_start", 32'(found), 1);
    endtask

    function automatic logic [15:0] ct_word(int n);
        return 16'(n) ^ 16'hA5A5;
    endfunction

    initial begin
        int exp_idx, guard, stalled;
        bit exp_done, ro;
        reset = 1'b0; set = 1'b0; readin = 1'b0; readout = 1'b0; full_in = 1'b0;
        data_type = '0; kyber_din = '0; kyber_in_index = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst");
        reset = 1'b1;
        step();
        check_zero("idle");
        set = 1'b1;
        step();
        chk("t1_type", 32'(input_type), 32'(TYPE_R));
        chk("t1_ok", 32'(readin_ok), 1);
        chk("t1_d1", 32'(kyber_dout_1), 0);
        chk("t1_d2", 32'(kyber_dout_2), 0);
        chk("t1_idx", 32'(kyber_out_index), 0);
        chk("t1_done", 32'(done), 0);

        // Byte-acceptance corner cases while loading r.
        vt[0] = '{4'd1, 16'd0,      8'h10, 1'b1, 0, 8'h10};
        vt[1] = '{4'd1, 16'd3,      8'h33, 1'b1, 3, 8'h33};
        vt[2] = '{4'd0, 16'd3,      8'hEE, 1'b1, 3, 8'h33};
        vt[3] = '{4'd1, 16'd3,      8'h44, 1'b0, 3, 8'h33};
        vt[4] = '{4'd1, 16'd32,     8'h99, 1'b1, 0, 8'h10};
        vt[5] = '{4'd4, 16'd0,      8'h98, 1'b1, 0, 8'h10};
        vt[6] = '{4'd1, 16'd3,      8'h77, 1'b1, 3, 8'h77};
        vt[7] = '{4'd1, 16'hFFE0,   8'h55, 1'b1, 0, 8'h10};
        for (int v = 0; v < 8; v++) begin
            send(vt[v].dt, vt[v].idx, vt[v].din, vt[v].rd, 1'b0, TYPE_R);
            chk($sformatf("tbl%0d", v), 32'(dut.buf_r[vt[v].chk_idx[SEED_AW-1:0]]), 32'(vt[v].exp));
        end

        load_phase(TYPE_R, 1'b1, 1'b0);
        load_phase(TYPE_T, 1'b0, 1'b1);
        load_phase(TYPE_M, 1'b0, 1'b0);
        load_phase(TYPE_RHO, 1'b0, 1'b0);

        // Full stream with random stalls plus a forced 3-cycle stall at pair 100.
        wait_stream();
        exp_idx = 0; exp_done = 0; guard = 0; stalled = 0;
        while (!exp_done && guard < 2000) begin
            chk("s_idx", 32'(kyber_out_index), 32'(exp_idx));
            chk("s_d1", 32'(kyber_dout_1), 32'(ct_word(2 * exp_idx)));
            chk("s_d2", 32'(kyber_dout_2), 32'(ct_word(2 * exp_idx + 1)));
            chk("s_done", 32'(done), 0);
            if (exp_idx == 100 && stalled < 3) begin ro = 1; stalled++; end
            else ro = ($urandom_range(0, 4) == 0);
            readout = ro;
            step();
            if (!ro) begin
                if (exp_idx == CT_PAIRS - 1) exp_done = 1;
                else exp_idx++;
            end
            guard++;
        end
        readout = 1'b0;
        chk("s_bound", 32'(guard < 2000), 1);
        chk("stall_seen", 32'(stalled), 3);
        for (int h = 0; h < 3; h++) begin
            chk("d_done", 32'(done), 1);
            chk("d_idx", 32'(kyber_out_index), 32'(CT_PAIRS - 1));
            chk("d_d1", 32'(kyber_dout_1), 32'(ct_word(CT_WORDS - 2)));
            chk("d_d2", 32'(kyber_dout_2), 32'(ct_word(CT_WORDS - 1)));
            readout = 1'($urandom_range(0, 1));
            step();
        end
        readout = 1'b0;

        // set=0 clears everything, set=1 restarts the load sequence.
        set = 1'b0;
        step();
        check_zero("set0");
        set = 1'b1;
        step();
        load_phase(TYPE_R, 1'b0, 1'b0);
        load_phase(TYPE_T, 1'b0, 1'b0);
        load_phase(TYPE_M, 1'b0, 1'b0);
        load_phase(TYPE_RHO, 1'b0, 1'b0);
        wait_stream();
        repeat (50) step();
        chk("p_idx", 32'(kyber_out_index), 50);
        chk("p5_d1", 32'(kyber_dout_1), 32'(ct_word(100)));

        // Asynchronous reset mid-stream clears outputs without waiting for a clock.
        reset = 1'b0;
        #1;
        check_zero("async");
        #2;
        reset = 1'b1;
        step();
        chk("rst_restart_type", 32'(input_type), 32'(TYPE_R));
        chk("rst_restart_ok", 32'(readin_ok), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
